seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_chk_pkg.sv | 23 ++
 rtl/seq_detect_ctrl_if.sv | 31 +++
 rtl/seq_match_core.sv | 57 +++++
 rtl/seq_detect_ctrl.sv | 156 +++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the serial sequence detector.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package seq_chk_pkg;

    // One-hot controller states; anything else is treated as illegal
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ARM  = 4'b0010,
        ST_SCAN = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    // Status codes carried on the timeout output while done is high
    localparam logic END_TARGET  = 1'b0;
    localparam logic END_TIMEOUT = 1'b1;

    // Fill counter width: it must hold values 0..pat_w inclusive
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Control/data bundle between a requester and seq_detect_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; data_vld qualifies each serial bit, no ready path.
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic             overlap_en;
    logic [CNT_W-1:0] target;
    logic [TMO_W-1:0] tmo_limit;
    logic             data_vld;
    logic             data_in;
    logic             busy;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt;
    logic             done;
    logic             timeout;

    modport master (
        output start, pattern, overlap_en, target, tmo_limit, data_vld, data_in,
        input  busy, hit, hit_cnt, done, timeout
    );

    modport slave (
        input  start, pattern, overlap_en, target, tmo_limit, data_vld, data_in,
        output busy, hit, hit_cnt, done, timeout
    );
endinterface

// File: rtl/seq_match_core.sv
// Shift register + fill counter + pattern compare for serial detection.
// Latency: match is combinational on the post-shift state of the current cycle.
// Backpressure: none; a bit is consumed on every cycle shift_en is high.
module seq_match_core
    import seq_chk_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);
    localparam int            FW   = fill_w(PAT_W);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [FW-1:0]    fill_inc;

    // Next shift/fill state and match on the post-shift view
    always_comb begin
        sr_d     = sr_q;
        fill_d   = fill_q;
        match    = 1'b0;
        fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        if (clear) begin
            sr_d   = '0;
            fill_d = '0;
        end else if (shift_en) begin
            sr_d   = {sr_q[PAT_W-2:0], bit_in};
            fill_d = fill_inc;
            if ((fill_inc == FULL) && (sr_d == pattern)) begin
                match = 1'b1;
                // Non-overlapping search needs PAT_W fresh bits for the next hit
                if (!overlap) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Search controller: IDLE->ARM->SCAN->DONE, counts pattern hits up to a target.
// Latency: hit/done registered, one cycle after the sampling edge; ARM costs one cycle.
// Backpressure: none; start ignored unless IDLE. Timeout via SEQ_DETECT_CTRL_TIMEOUT_EN.
module seq_detect_ctrl
    import seq_chk_pkg::*;
#(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_ctrl_if.slave   bus
);
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             busy_q, busy_d;
    logic             hit_q, hit_d;
    logic             done_q, done_d;
    logic             core_clr, core_shift, core_match;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic             unused_tmo;
    assign unused_tmo = ^bus.tmo_limit;
`endif

    seq_match_core #(.PAT_W(PAT_W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (core_clr),
        .shift_en (core_shift),
        .bit_in   (bus.data_in),
        .pattern  (pat_q),
        .overlap  (ovl_q),
        .match    (core_match)
    );

    // Next-state and output decode; the final hit takes priority over timeout
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        ovl_d      = ovl_q;
        tgt_d      = tgt_q;
        hit_cnt_d  = hit_cnt_q;
        hit_d      = 1'b0;
        done_d     = 1'b0;
        core_clr   = 1'b0;
        core_shift = 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        tmo_lim_d  = tmo_lim_q;
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = END_TARGET;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_ARM;
                    pat_d     = bus.pattern;
                    ovl_d     = bus.overlap_en;
                    tgt_d     = bus.target;
                    hit_cnt_d = '0;
                    core_clr  = 1'b1;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                    tmo_lim_d = bus.tmo_limit;
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_ARM: begin
                if (tgt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                core_shift = bus.data_vld;
                if (core_match) begin
                    hit_d     = 1'b1;
                    hit_cnt_d = hit_cnt_q + 1'b1;
                end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                if (core_match && (hit_cnt_d == tgt_q)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
                else if (tmo_cnt_d == tmo_lim_q) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = END_TIMEOUT;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_ARM) || (state_d == ST_SCAN);
    end

    // FSM, latched search parameters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            tgt_q     <= '0;
            hit_cnt_q <= '0;
            busy_q    <= 1'b0;
            hit_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            tmo_lim_q <= '0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            ovl_q     <= ovl_d;
            tgt_q     <= tgt_d;
            hit_cnt_q <= hit_cnt_d;
            busy_q    <= busy_d;
            hit_q     <= hit_d;
            done_q    <= done_d;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
            tmo_lim_q <= tmo_lim_d;
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.hit     = hit_q;
    assign bus.hit_cnt = hit_cnt_q;
    assign bus.done    = done_q;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl (PAT_W=5, CNT_W=8, TMO_W=16).
// Latency: inputs driven 1ns after each rising edge, outputs sampled there too.
// Backpressure: n/a; timeout expectations follow SEQ_DETECT_CTRL_TIMEOUT_EN.
module tb_seq_detect_ctrl;
    localparam int PAT_W = 5;
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) bus ();

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [PAT_W-1:0] pat, input logic ovl,
                            input logic [CNT_W-1:0] tgt, input logic [TMO_W-1:0] tmo);
        bus.start      = 1'b1;
        bus.pattern    = pat;
        bus.overlap_en = ovl;
        bus.target     = tgt;
        bus.tmo_limit  = tmo;
        step();
        bus.start      = 1'b0;
    endtask

    // Feed n bits MSB first; bit index i of the masks is set when hit/done follows bits[i]
    task automatic feed(input logic [15:0] bits, input int n,
                        output logic [15:0] hit_m, output logic [15:0] done_m,
                        output logic [CNT_W-1:0] cnt_end, output logic tmo_done);
        hit_m    = '0;
        done_m   = '0;
        tmo_done = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.data_vld = 1'b1;
            bus.data_in  = bits[i];
            step();
            hit_m[i]  = bus.hit;
            done_m[i] = bus.done;
            if (bus.done) tmo_done = bus.timeout;
        end
        bus.data_vld = 1'b0;
        bus.data_in  = 1'b0;
        cnt_end      = bus.hit_cnt;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        n_run++;
        if ({bus.busy, bus.hit, bus.done, bus.timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.hit, bus.done, bus.timeout});
        end
        n_run++;
        if (bus.hit_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_hit_cnt got %0d want 0", bus.hit_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        logic [15:0] hm, dm;
        logic [CNT_W-1:0] c;
        logic t;
        do_start(5'b10010, 1'b0, 8'd2, 16'd1000);
        n_run++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nov_busy_arm got %b want 1", bus.busy);
        end
        step();
        feed(16'b1001010010, 10, hm, dm, c, t);
        n_run++;
        if (hm[9:0] !== 10'b0000100001) begin
            n_fail++;
            $display("FAIL nov_hits got %b want 0000100001", hm[9:0]);
        end
        n_run++;
        if ({dm[9:0], c, t} !== {10'b0000000001, 8'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL nov_done got done=%b cnt=%0d tmo=%b want 0000000001/2/0", dm[9:0], c, t);
        end
        step();
        n_run++;
        if ({bus.done, bus.busy, bus.hit_cnt} !== {1'b0, 1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL nov_after got done=%b busy=%b cnt=%0d want 0/0/2", bus.done, bus.busy, bus.hit_cnt);
        end
    endtask

    task automatic test_target_zero();
        logic hit_seen;
        do_start(5'b10010, 1'b0, 8'd0, 16'd1000);
        n_run++;
        if (bus.hit_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL tz_cnt_clear got %0d want 0", bus.hit_cnt);
        end
        hit_seen = bus.hit;
        step();
        hit_seen = hit_seen | bus.hit;
        n_run++;
        if ({bus.done, bus.timeout, bus.busy, bus.hit_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL tz_done got done=%b tmo=%b busy=%b cnt=%0d want 1/0/0/0",
                     bus.done, bus.timeout, bus.busy, bus.hit_cnt);
        end
        step();
        hit_seen = hit_seen | bus.hit;
        n_run++;
        if ({bus.done, hit_seen} !== 2'b00) begin
            n_fail++;
            $display("FAIL tz_after got done=%b hit_seen=%b want 0/0", bus.done, hit_seen);
        end
    endtask

    task automatic test_overlap();
        logic [15:0] hm, dm;
        logic [CNT_W-1:0] c;
        logic t;
        do_start(5'b10010, 1'b1, 8'd2, 16'd1000);
        step();
        feed(16'b10010010, 8, hm, dm, c, t);
        n_run++;
        if ({hm[7:0], dm[7:0], c} !== {8'b00001001, 8'b00000001, 8'd2}) begin
            n_fail++;
            $display("FAIL ovl_on got hits=%b done=%b cnt=%0d want 00001001/00000001/2", hm[7:0], dm[7:0], c);
        end
        step();
        do_start(5'b10010, 1'b0, 8'd2, 16'd1000);
        step();
        feed(16'b10010010, 8, hm, dm, c, t);
        n_run++;
        if ({hm[7:0], dm[7:0], c, bus.busy} !== {8'b00001000, 8'b00000000, 8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL ovl_off got hits=%b done=%b cnt=%0d busy=%b want 00001000/00000000/1/1",
                     hm[7:0], dm[7:0], c, bus.busy);
        end
        pulse_reset();
    endtask

    task automatic test_timeout();
        int done_at = 0;
        logic hit_seen = 1'b0;
        logic tmo_at = 1'b0;
        logic busy_19 = 1'b0;
        do_start(5'b10010, 1'b0, 8'd3, 16'd20);
        step();
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            bus.data_vld = k[0];
            bus.data_in  = 1'b0;
            step();
            hit_seen = hit_seen | bus.hit;
            if (k == 19) busy_19 = bus.busy;
            if (bus.done) begin
                done_at = k;
                tmo_at  = bus.timeout;
            end
        end
        bus.data_vld = 1'b0;
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
        n_run++;
        if ({done_at, tmo_at, busy_19} !== {32'd20, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL tmo_end got done_cycle=%0d tmo=%b busy19=%b want 20/1/1", done_at, tmo_at, busy_19);
        end
        n_run++;
        if ({bus.hit_cnt, hit_seen} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL tmo_cnt got cnt=%0d hit_seen=%b want 0/0", bus.hit_cnt, hit_seen);
        end
        step();
`else
        n_run++;
        if ({done_at, bus.busy, bus.timeout} !== {32'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL notmo_run got done_cycle=%0d busy=%b tmo=%b want 0/1/0", done_at, bus.busy, bus.timeout);
        end
        n_run++;
        if ({bus.hit_cnt, hit_seen} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL notmo_cnt got cnt=%0d hit_seen=%b want 0/0", bus.hit_cnt, hit_seen);
        end
        pulse_reset();
`endif
    endtask

    task automatic test_match_tmo_start_ignored();
        logic [15:0] hm, dm;
        logic [CNT_W-1:0] c;
        logic t;
        do_start(5'b10010, 1'b0, 8'd1, 16'd5);
        step();
        bus.start   = 1'b1;
        bus.pattern = 5'b11111;
        bus.target  = 8'd0;
        feed(16'b10010, 5, hm, dm, c, t);
        bus.start   = 1'b0;
        n_run++;
        if ({hm[4:0], dm[4:0], c, t} !== {5'b00001, 5'b00001, 8'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL race_final got hits=%b done=%b cnt=%0d tmo=%b want 00001/00001/1/0",
                     hm[4:0], dm[4:0], c, t);
        end
        step();
        n_run++;
        if ({bus.busy, bus.done, bus.hit_cnt} !== {1'b0, 1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL race_after got busy=%b done=%b cnt=%0d want 0/0/1", bus.busy, bus.done, bus.hit_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] hm, dm;
        logic [CNT_W-1:0] c;
        logic t;
        logic done_seen = 1'b0;
        do_start(5'b10010, 1'b1, 8'd5, 16'd1000);
        step();
        feed(16'b10010010010, 11, hm, dm, c, t);
        n_run++;
        if ({hm[10:0], c, bus.busy} !== {11'b00001001001, 8'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL rmid_hits got hits=%b cnt=%0d busy=%b want 00001001001/3/1", hm[10:0], c, bus.busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_run++;
        if ({bus.busy, bus.hit, bus.done, bus.timeout, bus.hit_cnt} !== 12'd0) begin
            n_fail++;
            $display("FAIL rmid_async got busy=%b hit=%b done=%b tmo=%b cnt=%0d want all 0",
                     bus.busy, bus.hit, bus.done, bus.timeout, bus.hit_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            done_seen = done_seen | bus.done;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            done_seen = done_seen | bus.done;
        end
        n_run++;
        if ({done_seen, bus.busy, bus.hit_cnt} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL rmid_after got done_seen=%b busy=%b cnt=%0d want 0/0/0", done_seen, bus.busy, bus.hit_cnt);
        end
        do_start(5'b10010, 1'b0, 8'd0, 16'd1000);
        step();
        n_run++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_idle_restart got done=%b want 1", bus.done);
        end
        step();
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.pattern    = '0;
        bus.overlap_en = 1'b0;
        bus.target     = '0;
        bus.tmo_limit  = '0;
        bus.data_vld   = 1'b0;
        bus.data_in    = 1'b0;
        step();
        step();
        test_reset();
        rst = 1'b0;
        step();
        test_nonoverlap();
        test_target_zero();
        test_overlap();
        test_timeout();
        test_match_tmo_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
